pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer with a paced execution tick, relative branching and a hardware return-address stack for call/return. It sits between the instruction decoder, which supplies `pc_op_i` and `pc_i`, and the instruction memory address port, which consumes `pc_o`. It generalises the fixed 4-bit, 10 M-cycle counter to configurable width, step, pacing and stack depth, and adds link, stack status and error flags.

## Interface
- `ANCHO`, default 8: PC, target and link width in bits.
- `STEP`, default 4: increment added by sequential and link operations.
- `DIV`, default 10000000: clocks per execution tick. Must be ≥ 1; `DIV`=1 means a tick on every cycle.
- `PILA`, default 4: return-stack depth in entries. Must be ≥ 1.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `pc_i`, in, `ANCHO`: absolute target (ops 011/100) or signed two's-complement offset (op 110).
- `pc_op_i`, in, 3: operation code, sampled only on tick edges.
- `pc_o`, out, `ANCHO`: current program counter.
- `pcinc_o`, out, `ANCHO`: last link value.
- `tick_o`, out, 1: combinational. High when the divider count is `DIV`-1, meaning the next edge executes `pc_op_i`.
- `depth_o`, out, `$clog2(PILA+1)`: number of valid stack entries.
- `overflow_o`, out, 1: sticky. Set when a call is attempted with a full stack.
- `underflow_o`, out, 1: sticky. Set when a return is attempted with an empty stack.

## Operation
- Divider count `cnt` has width max(1, `$clog2(DIV)`).
  - Counts 0..`DIV`-1, then wraps to 0.
  - `tick_o` = (`cnt` == `DIV`-1).
- Between ticks, `pc_o`, `pcinc_o`, the stack and the flags hold.
- On a tick edge, `pc_op_i` executes:
  - 000 clear: `pc_o`←0, `pcinc_o`←0, stack emptied, `overflow_o`←0, `underflow_o`←0.
  - 001 hold: no change.
  - 010 step: `pc_o`←`pc_o`+`STEP`.
  - 011 jump-and-link: `pcinc_o`←`pc_o`+`STEP`, `pc_o`←`pc_i`. Stack is untouched.
  - 100 call:
    - If `depth_o` < `PILA`: push `pc_o`+`STEP`, `pcinc_o`←`pc_o`+`STEP`, `pc_o`←`pc_i`.
    - If the stack is full: no push, `pc_o` and `pcinc_o` hold, `overflow_o`←1.
  - 101 return:
    - If `depth_o` > 0: `pc_o`←top entry, then pop.
    - If the stack is empty: `pc_o` holds, `underflow_o`←1.
  - 110 relative branch: `pc_o`←`pc_o`+`pc_i`, with `pc_i` sign-interpreted.
  - 111 reserved: behaves as hold.
- Arithmetic rules:
  - All sums are modulo 2^`ANCHO`. Wrap-around is silent and raises no flag.
  - `STEP` is truncated to `ANCHO` bits.
- Stack behaviour:
  - LIFO structure: register array plus pointer.
  - Push and pop never occur in the same tick.
  - Entries above `depth_o` are don't-care.
- Flags stay set until reset or op 000.

## Timing
- Reset values: `pc_o`=0, `pcinc_o`=0, `cnt`=0, `depth_o`=0, `overflow_o`=0, `underflow_o`=0, `tick_o`=0 (or 1 when `DIV`=1).
- The first tick after reset deassertion occurs on the `DIV`-th edge, counting the first edge with `reset` low as edge 1.
- Latency: `pc_op_i`/`pc_i` are sampled on the tick edge. Results are visible on `pc_o`, `pcinc_o`, `depth_o` and the flags immediately after that edge (1-cycle latency). `pc_op_i` is ignored on all other edges.
- Reset mid-count or mid-operation: `reset` wins over everything on the same edge.
  - `cnt` returns to 0.
  - The pending op is discarded.
  - The stack is emptied.
- Reset semantics of op 000:
  - Op 000 does not reset `cnt`; pacing continues unbroken.
  - Hardware `reset` does reset `cnt`.
- Ops are independent of each other; a call followed by a return on consecutive ticks is legal.

## Test plan
All scenarios use `ANCHO`=8, `STEP`=4, `DIV`=4, `PILA`=2.
- Reset and pacing: hold `reset` 2 cycles, then `pc_op_i`=010 constant.
  - `tick_o` is high every 4th cycle.
  - `pc_o` steps 0→4→8→12 on successive ticks and never changes between ticks.
- Wrap-around: step from `pc_o`=252 -> `pc_o`=0. Relative branch with `pc_i`=8'hF8 (−8) from 4 -> `pc_o`=252.
- Call/return nesting:
  - At `pc_o`=8, call 0x40 -> `pc_o`=0x40, `pcinc_o`=12, `depth_o`=1.
  - Call 0x80 -> `pc_o`=0x80, `pcinc_o`=0x44, `depth_o`=2.
  - Return -> `pc_o`=0x44. Return -> `pc_o`=12, `depth_o`=0.
- Overflow/underflow:
  - A third call with `depth_o`=2 -> `pc_o` unchanged, `overflow_o`=1, `depth_o`=2.
  - Three returns -> the third sets `underflow_o`=1 with `pc_o` held.
  - Op 000 -> both flags are 0 and `pc_o`=0.
- Jump-and-link: `pc_o`=0x10, op 011, `pc_i`=0x30 -> `pc_o`=0x30, `pcinc_o`=0x14, `depth_o` unchanged.
- Reset mid-operation:
  - Assert `reset` at `cnt`=2 with `depth_o`=1 and `pc_o`=0x40 -> next cycle all outputs are 0.
  - The next tick falls 4 edges after `reset` deasserts.

Source files
------------

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Decoder-side bus of the program-counter sequencer.
//                The decoder (master) supplies the operation and its
//                target/offset. The sequencer (slave) returns the current
//                PC, the last link value, the tick strobe, the stack depth
//                and the sticky error flags.
//  Signals     : pc_i        target address or signed offset (ANCHO bits)
//                pc_op_i     3-bit operation code
//                pc_o        current program counter
//                pcinc_o     last link value (return address)
//                tick_o      next clock edge executes pc_op_i
//                depth_o     number of valid return-stack entries
//                overflow_o  sticky: call attempted with a full stack
//                underflow_o sticky: return attempted with an empty stack
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int ANCHO = 8,
    parameter int PILA  = 4
);
    localparam int DEPTH_W = $clog2(PILA + 1);

    logic [ANCHO-1:0]   pc_i;
    logic [2:0]         pc_op_i;
    logic [ANCHO-1:0]   pc_o;
    logic [ANCHO-1:0]   pcinc_o;
    logic               tick_o;
    logic [DEPTH_W-1:0] depth_o;
    logic               overflow_o;
    logic               underflow_o;

    modport master (
        output pc_i,
        output pc_op_i,
        input  pc_o,
        input  pcinc_o,
        input  tick_o,
        input  depth_o,
        input  overflow_o,
        input  underflow_o
    );

    modport slave (
        input  pc_i,
        input  pc_op_i,
        output pc_o,
        output pcinc_o,
        output tick_o,
        output depth_o,
        output overflow_o,
        output underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer with a paced execution tick,
//                relative branching and a hardware return-address stack.
//                A free-running divider produces one tick every DIV clocks;
//                only the edge following a high tick executes pc_op_i.
//  Ports       : clk    rising-edge clock
//                reset  synchronous active-high reset
//                bus    pc_sequencer_if.slave (see interface header)
//  Parameters  : ANCHO  PC / target / link width
//                STEP   increment for step and link (truncated to ANCHO)
//                DIV    clocks per execution tick (>= 1)
//                PILA   return-stack depth (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int ANCHO = 8,
    parameter int STEP  = 4,
    parameter int DIV   = 10000000,
    parameter int PILA  = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    pc_sequencer_if.slave bus
);

    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH_W = $clog2(PILA + 1);
    localparam int IDX_W   = (PILA > 1) ? $clog2(PILA) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [ANCHO-1:0]   STEP_W     = ANCHO'(STEP);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(PILA);

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_HOLD  = 3'b001;
    localparam logic [2:0] OP_STEP  = 3'b010;
    localparam logic [2:0] OP_JAL   = 3'b011;
    localparam logic [2:0] OP_CALL  = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;
    localparam logic [2:0] OP_REL   = 3'b110;

    // ------------------------------------------------------------------
    // Execution pacing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             tick;

    // With DIV == 1 the counter is pinned at 0 == CNT_LAST, so every
    // cycle ticks.
    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [ANCHO-1:0]   pc;
    logic [ANCHO-1:0]   pcinc;
    logic [DEPTH_W-1:0] depth;
    logic               overflow;
    logic               underflow;
    logic [ANCHO-1:0]   stack [PILA];

    logic [ANCHO-1:0]   next_seq;
    logic               stack_full;
    logic               stack_empty;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;
    logic [ANCHO-1:0]   top_entry;
    logic               do_push;

    assign next_seq    = pc + STEP_W;
    assign stack_full  = (depth == DEPTH_FULL);
    assign stack_empty = (depth == '0);

    // depth is one wider than an entry index (it must also encode "full");
    // the push slot is depth itself, the top of stack is depth-1. Both are
    // only used when the corresponding fullness guard holds, so the
    // truncation never drops a meaningful bit.
    assign push_idx  = IDX_W'(depth);
    assign top_idx   = IDX_W'(depth - DEPTH_W'(1));
    assign top_entry = stack[top_idx];

    assign do_push = tick && (bus.pc_op_i == OP_CALL) && !stack_full;

    // Stack storage carries no reset: entries at or above depth are
    // never read, so emptying the stack only needs depth <= 0.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            stack[push_idx] <= next_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            pcinc     <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (tick) begin
            case (bus.pc_op_i)
                OP_CLEAR: begin
                    pc        <= '0;
                    pcinc     <= '0;
                    depth     <= '0;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
                OP_HOLD: begin
                end
                OP_STEP: begin
                    pc <= next_seq;
                end
                OP_JAL: begin
                    pcinc <= next_seq;
                    pc    <= bus.pc_i;
                end
                OP_CALL: begin
                    if (stack_full) begin
                        overflow <= 1'b1;
                    end else begin
                        pcinc <= next_seq;
                        pc    <= bus.pc_i;
                        depth <= depth + DEPTH_W'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        underflow <= 1'b1;
                    end else begin
                        pc    <= top_entry;
                        depth <= depth - DEPTH_W'(1);
                    end
                end
                // Two's-complement add of the offset is the same bit
                // pattern as an unsigned modulo add, so no sign extension
                // is needed at equal widths.
                OP_REL: begin
                    pc <= pc + bus.pc_i;
                end
                default: begin
                    // 3'b111 is reserved and behaves as hold.
                end
            endcase
        end
    end

    assign bus.pc_o        = pc;
    assign bus.pcinc_o     = pcinc;
    assign bus.tick_o      = tick;
    assign bus.depth_o     = depth;
    assign bus.overflow_o  = overflow;
    assign bus.underflow_o = underflow;

endmodule
`default_nettype wire
